// File: rtl/lct_l1a_match_pkg.sv
// Shared constants for the LCT/L1A match block: default sizes, event
// record width and the bit layout of a packed FIFO entry.
package lct_l1a_match_pkg;

   localparam int NCH_DEFAULT     = 5;
   localparam int MAXWIN_DEFAULT  = 8;
   localparam int FDEPTH_DEFAULT  = 4;
   localparam int L1A_NUM_W       = 8;
   localparam int ENTRY_W_DEFAULT = L1A_NUM_W + NCH_DEFAULT;

   // Entry layout: match mask in the low NCH bits, L1A number directly above.
   localparam int MASK_LSB = 0;

   typedef logic [L1A_NUM_W-1:0] l1a_num_t;

   typedef struct packed {
      l1a_num_t                 num;
      logic [NCH_DEFAULT-1:0]   mask;
   } evt_t;

   function automatic int num_lsb(input int nch);
      return MASK_LSB + nch;
   endfunction

   function automatic int entry_w(input int nch);
      return L1A_NUM_W + nch;
   endfunction

endpackage

// File: rtl/lct_evt_fifo.sv
// Small first-word-fall-through event FIFO; pushes into a full FIFO are
// dropped and latch a sticky overflow flag unless a pop frees a slot.
module lct_evt_fifo
   import lct_l1a_match_pkg::*;
#(
   parameter int W     = ENTRY_W_DEFAULT,
   parameter int DEPTH = FDEPTH_DEFAULT
)(
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         rdy,
   output logic         vld,
   output logic [W-1:0] head,
   output logic         ovfl
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          do_pop;
   logic          do_push;
   logic          drop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = rdy & ~empty;
   // A pop in the same cycle makes room, so a full FIFO still accepts the push.
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovfl   <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
         if (drop)
            ovfl <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   assign vld  = ~empty;
   assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/lct_l1a_match.sv
// Matches delayed LCT bits against L1A windows and queues one
// {L1A number, per-CFEB mask} record per accepted L1A.
module lct_l1a_match
   import lct_l1a_match_pkg::*;
#(
   parameter int NCH    = NCH_DEFAULT,
   parameter int MAXWIN = MAXWIN_DEFAULT,
   parameter int FDEPTH = FDEPTH_DEFAULT
)(
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic                      CE,
   input  logic [NCH-1:0]            LCT,
   input  logic                      L1A,
   input  logic [$clog2(MAXWIN)-1:0] WIN_SEL,
   output logic                      OUT_VLD,
   input  logic                      OUT_RDY,
   output logic [L1A_NUM_W-1:0]      OUT_L1A_NUM,
   output logic [NCH-1:0]            OUT_MASK,
   output logic                      OUT_MATCH,
   output logic                      OVFL,
   output logic [L1A_NUM_W-1:0]      L1A_CNT
);

   localparam int WSW = $clog2(MAXWIN);
   // The live LCT sample is the newest window slot, so MAXWIN-1 stored
   // stages give a full MAXWIN-sample window.
   localparam int HD  = MAXWIN - 1;
   localparam int EW  = entry_w(NCH);

   logic [NCH-1:0]       hist     [HD];
   logic [HD-1:0]        pipe_vld;
   l1a_num_t             pipe_num [HD];
   logic [WSW-1:0]       win;
   l1a_num_t             l1a_cnt;
   logic                 accept;
   logic                 end_vld;
   l1a_num_t             end_num;
   logic [NCH-1:0]       win_mask;
   logic                 push;
   logic [EW-1:0]        push_data;
   logic [EW-1:0]        head;

   assign accept = L1A & CE;

   // History, L1A pipeline and counter; the window length only reloads when
   // nothing is in flight so open windows keep the length they started with.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int k = 0; k < HD; k++) begin
            hist[k]     <= '0;
            pipe_num[k] <= '0;
         end
         pipe_vld <= '0;
         win      <= '0;
         l1a_cnt  <= '0;
      end else begin
         if (CE) begin
            hist[0]     <= LCT;
            pipe_vld[0] <= accept;
            pipe_num[0] <= l1a_cnt;
            for (int k = 1; k < HD; k++) begin
               hist[k]     <= hist[k-1];
               pipe_vld[k] <= pipe_vld[k-1];
               pipe_num[k] <= pipe_num[k-1];
            end
         end
         if (accept)
            l1a_cnt <= l1a_cnt + 1'b1;
         if (!(|pipe_vld) && !L1A)
            win <= WIN_SEL;
      end
   end

   // The L1A whose window closes this cycle sits win stages back; its mask
   // is the live sample ORed with the win most recent stored samples.
   always_comb begin
      end_vld  = accept;
      end_num  = l1a_cnt;
      if (win != '0) begin
         end_vld = pipe_vld[win - 1'b1];
         end_num = pipe_num[win - 1'b1];
      end
      win_mask = LCT;
      for (int k = 0; k < HD; k++) begin
         if (WSW'(k) < win)
            win_mask = win_mask | hist[k];
      end
   end

   assign push      = CE & end_vld;
   assign push_data = {end_num, win_mask};

   lct_evt_fifo #(
      .W     (EW),
      .DEPTH (FDEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .push      (push),
      .push_data (push_data),
      .rdy       (OUT_RDY),
      .vld       (OUT_VLD),
      .head      (head),
      .ovfl      (OVFL)
   );

   assign OUT_L1A_NUM = head[num_lsb(NCH) +: L1A_NUM_W];
   assign OUT_MASK    = head[MASK_LSB +: NCH];
   assign OUT_MATCH   = |OUT_MASK;
   assign L1A_CNT     = l1a_cnt;

endmodule

// File: tb/tb_lct_l1a_match.sv
// Bench for lct_l1a_match: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based event model.
module tb_lct_l1a_match;

   localparam int NCH    = 5;
   localparam int MAXWIN = 8;
   localparam int FDEPTH = 4;

   logic           CLK = 1'b0;
   logic           RST_N = 1'b0;
   logic           CE = 1'b0;
   logic [NCH-1:0] LCT = '0;
   logic           L1A = 1'b0;
   logic [2:0]     WIN_SEL = 3'd3;
   logic           OUT_VLD;
   logic           OUT_RDY = 1'b0;
   logic [7:0]     OUT_L1A_NUM;
   logic [NCH-1:0] OUT_MASK;
   logic           OUT_MATCH;
   logic           OVFL;
   logic [7:0]     L1A_CNT;

   always #5 CLK = ~CLK;

   lct_l1a_match #(
      .NCH    (NCH),
      .MAXWIN (MAXWIN),
      .FDEPTH (FDEPTH)
   ) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .CE          (CE),
      .LCT         (LCT),
      .L1A         (L1A),
      .WIN_SEL     (WIN_SEL),
      .OUT_VLD     (OUT_VLD),
      .OUT_RDY     (OUT_RDY),
      .OUT_L1A_NUM (OUT_L1A_NUM),
      .OUT_MASK    (OUT_MASK),
      .OUT_MATCH   (OUT_MATCH),
      .OVFL        (OVFL),
      .L1A_CNT     (L1A_CNT)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {int num; int mask;} ent_t;
   typedef struct {int num; int start; int w;} pend_t;

   ent_t  mfifo[$];
   pend_t mpend[$];
   int    m_cnt = 0;
   int    m_ce = 0;
   bit    m_ovfl = 1'b0;
   int    samp[64];
   bit    model_on = 1'b0;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Event-level model: windows are counted in CE-cycles and masks are ORs
   // over the recorded samples of each L1A's window.
   task automatic modelStep();
      ent_t e;
      bit   do_pop;
      bit   do_push;
      int   m;
      do_push = 1'b0;
      e.num   = 0;
      e.mask  = 0;
      if (!RST_N) begin
         mfifo.delete();
         mpend.delete();
         m_cnt  = 0;
         m_ovfl = 1'b0;
         m_ce   = 0;
         return;
      end
      do_pop = (mfifo.size() > 0) && OUT_RDY;
      if (CE) begin
         samp[m_ce % 64] = int'(LCT);
         if (L1A) begin
            mpend.push_back('{m_cnt, m_ce, int'(WIN_SEL) + 1});
            m_cnt = (m_cnt + 1) % 256;
         end
         if (mpend.size() > 0 && mpend[0].start + mpend[0].w - 1 == m_ce) begin
            m = 0;
            for (int c = mpend[0].start; c <= m_ce; c++)
               m = m | samp[c % 64];
            e.num   = mpend[0].num;
            e.mask  = m;
            do_push = 1'b1;
            void'(mpend.pop_front());
         end
         m_ce++;
      end
      if (do_pop)
         void'(mfifo.pop_front());
      if (do_push) begin
         if (mfifo.size() < FDEPTH)
            mfifo.push_back(e);
         else
            m_ovfl = 1'b1;
      end
   endtask

   always @(negedge CLK) begin
      if (model_on) begin
         checkOutput("out_vld", int'(OUT_VLD), int'(mfifo.size() > 0));
         if (mfifo.size() > 0) begin
            checkOutput("out_l1a_num", int'(OUT_L1A_NUM), mfifo[0].num);
            checkOutput("out_mask", int'(OUT_MASK), mfifo[0].mask);
            checkOutput("out_match", int'(OUT_MATCH), int'(mfifo[0].mask != 0));
         end
         checkOutput("ovfl", int'(OVFL), int'(m_ovfl));
         checkOutput("l1a_cnt", int'(L1A_CNT), m_cnt);
      end
   end

   task automatic applyStimulus(input bit rst_n, input bit l1a, input bit ce,
                                input bit rdy, input logic [NCH-1:0] lct);
      RST_N   = rst_n;
      L1A     = l1a;
      CE      = ce;
      OUT_RDY = rdy;
      LCT     = lct;
      @(posedge CLK);
      modelStep();
      #1;
   endtask

   task automatic doReset(input int w);
      WIN_SEL = 3'(w - 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
   endtask

   task automatic changeWin(input int w);
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, '0);
      WIN_SEL = 3'(w - 1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, '0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, '0);
   endtask

   initial begin
      int wlist[4];
      wlist = '{3, 1, 8, 6};

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
      model_on = 1'b1;
      checkOutput("reset_vld", int'(OUT_VLD), 0);
      checkOutput("reset_cnt", int'(L1A_CNT), 0);
      checkOutput("reset_ovfl", int'(OVFL), 0);

      // W=4, single hit in the middle of the window
      doReset(4);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'b00000);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'b00000);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'b00100);
      checkOutput("t1_vld_early", int'(OUT_VLD), 0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'b00000);
      checkOutput("t1_vld", int'(OUT_VLD), 1);
      checkOutput("t1_num", int'(OUT_L1A_NUM), 0);
      checkOutput("t1_mask", int'(OUT_MASK), 4);
      checkOutput("t1_match", int'(OUT_MATCH), 1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 5'b00000);
      checkOutput("t1_popped", int'(OUT_VLD), 0);

      // W=4, hits just outside both ends of the window
      doReset(4);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'b00100);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'b00000);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'b00000);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'b00000);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'b00000);
      checkOutput("t2_vld", int'(OUT_VLD), 1);
      checkOutput("t2_mask", int'(OUT_MASK), 0);
      checkOutput("t2_match", int'(OUT_MATCH), 0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 5'b00100);
      checkOutput("t2_popped", int'(OUT_VLD), 0);

      // W=4, overlapping windows sharing samples
      doReset(4);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'b00000);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'b00000);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'b00000);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'b00000);
      checkOutput("t3_num0", int'(OUT_L1A_NUM), 0);
      checkOutput("t3_mask0", int'(OUT_MASK), 0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 5'b00001);
      checkOutput("t3_vld1", int'(OUT_VLD), 1);
      checkOutput("t3_num1", int'(OUT_L1A_NUM), 1);
      checkOutput("t3_mask1", int'(OUT_MASK), 1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 5'b00000);

      // W=1, consumer stalled until the FIFO overflows
      doReset(1);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'b00000);
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'b00000);
      end
      checkOutput("t4_ovfl", int'(OVFL), 1);
      checkOutput("t4_cnt", int'(L1A_CNT), 6);
      for (int i = 0; i < 4; i++) begin
         checkOutput("t4_order", int'(OUT_L1A_NUM), i);
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 5'b00000);
      end
      checkOutput("t4_drained", int'(OUT_VLD), 0);
      checkOutput("t4_ovfl_sticky", int'(OVFL), 1);

      // W=8 with three CE-low cycles; the only hit lands in a stalled cycle
      doReset(8);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'b00000);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'b00000);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'b10000);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'b00000);
      checkOutput("t5_vld_early", int'(OUT_VLD), 0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'b00000);
      checkOutput("t5_vld", int'(OUT_VLD), 1);
      checkOutput("t5_mask", int'(OUT_MASK), 0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 5'b00000);

      // W=4, reset lands inside an open window
      doReset(4);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'b11111);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'b11111);
      checkOutput("t6_cnt_before", int'(L1A_CNT), 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'b11111);
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'b00000);
      checkOutput("t6_no_entry", int'(OUT_VLD), 0);
      checkOutput("t6_cnt", int'(L1A_CNT), 0);
      checkOutput("t6_ovfl", int'(OVFL), 0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'b00000);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'b00000);
      checkOutput("t6_vld_next", int'(OUT_VLD), 1);
      checkOutput("t6_num_next", int'(OUT_L1A_NUM), 0);

      // Randomized traffic with CE stalls and back-pressure
      doReset(4);
      foreach (wlist[p]) begin
         changeWin(wlist[p]);
         for (int i = 0; i < 200; i++)
            applyStimulus(1'b1, ($urandom % 4) == 0, ($urandom % 8) != 0,
                          ($urandom % 3) != 0, NCH'($urandom & $urandom));
      end
      for (int i = 0; i < 20; i++)
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, '0);
      checkOutput("final_drained", int'(OUT_VLD), 0);

      @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
